// File: rtl/pp_sweep_ctrl.sv
// rtl/pp_sweep_ctrl.sv - p-vector memory sweep sequencer: stream a block out, write updates back in place
// Host load writes reach the memory only while idle; a sweep never writes ahead of its own reads.
module pp_sweep_ctrl #(
    parameter int ELEMENT_WIDTH = 64,
    parameter int NO_OF_UNITS   = 8,
    parameter int ADDRESS_WIDTH = 20,
    parameter int MEM_DEPTH     = 1001,
    localparam int W            = NO_OF_UNITS * ELEMENT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_address,
    input  logic [ADDRESS_WIDTH-1:0] length,
    output logic                     busy,
    output logic                     finish,
    output logic                     error,
    output logic [W-1:0]             out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic [W-1:0]             in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [ADDRESS_WIDTH-1:0] mem_read_address,
    input  logic [W-1:0]             mem_data,
    output logic                     mem_write_enable,
    output logic [ADDRESS_WIDTH-1:0] mem_write_address,
    output logic [W-1:0]             mem_write_data,
    input  logic                     host_write_enable,
    input  logic [ADDRESS_WIDTH-1:0] host_write_address,
    input  logic [W-1:0]             host_data
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [ADDRESS_WIDTH-1:0] r_base;
    logic [ADDRESS_WIDTH-1:0] r_len;
    logic [ADDRESS_WIDTH-1:0] r_rd_cnt;
    logic [ADDRESS_WIDTH-1:0] r_wr_cnt;
    logic [W-1:0]             r_out_data;
    logic                     r_out_valid;
    logic                     r_error;

    logic [ADDRESS_WIDTH:0]   w_end;
    logic                     w_in_range;
    logic                     w_start_idle;
    logic                     w_reject;
    logic                     w_load;
    logic                     w_in_ready;
    logic                     w_wr_fire;
    logic                     w_last_wr;
    logic                     w_host_fire;
    logic                     w_host_drop;

    // End of block is formed one bit wider so a wrapping sum cannot pass the range check.
    assign w_end        = {1'b0, base_address} + {1'b0, length};
    assign w_in_range   = w_end <= (ADDRESS_WIDTH+1)'(MEM_DEPTH);
    assign w_start_idle = start && (r_state == S_IDLE);
    assign w_reject     = w_start_idle && (length != '0) && !w_in_range;

    assign w_load      = (r_state == S_RUN) && (r_rd_cnt < r_len) && (!r_out_valid || out_ready);
    assign w_in_ready  = (r_state == S_RUN) && (r_wr_cnt < r_rd_cnt) && (r_wr_cnt < r_len);
    assign w_wr_fire   = in_valid && w_in_ready;
    assign w_last_wr   = w_wr_fire && ((r_wr_cnt + ADDRESS_WIDTH'(1)) == r_len);
    assign w_host_fire = host_write_enable && (r_state == S_IDLE);
    assign w_host_drop = host_write_enable && (r_state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        w_next_state = S_DONE;
                    end else if (w_in_range) begin
                        w_next_state = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_last_wr) begin
                    w_next_state = S_DONE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy              = (r_state == S_RUN);
        finish            = (r_state == S_DONE);
        error             = r_error;
        out_data          = r_out_data;
        out_valid         = r_out_valid;
        in_ready          = w_in_ready;
        mem_read_address  = r_base + r_rd_cnt;
        mem_write_enable  = w_wr_fire || w_host_fire;
        mem_write_address = host_write_address;
        mem_write_data    = host_data;
        if (r_state == S_RUN) begin
            mem_write_address = r_base + r_wr_cnt;
            mem_write_data    = in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base      <= '0;
            r_len       <= '0;
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_error <= w_reject || w_host_drop;
            if (w_start_idle && (w_next_state == S_RUN)) begin
                r_base   <= base_address;
                r_len    <= length;
                r_rd_cnt <= '0;
                r_wr_cnt <= '0;
            end else if (r_state == S_RUN) begin
                if (w_load) begin
                    r_rd_cnt <= r_rd_cnt + ADDRESS_WIDTH'(1);
                end
                if (w_wr_fire) begin
                    r_wr_cnt <= r_wr_cnt + ADDRESS_WIDTH'(1);
                end
            end
            // The output word is only presented while the sweep is live.
            if ((r_state != S_RUN) || (w_next_state != S_RUN)) begin
                r_out_valid <= 1'b0;
            end else if (w_load) begin
                r_out_data  <= mem_data;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
